// File: rtl/tick_pkg.sv
// Shared types for tick-driven timers and other tick consumers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tick_pkg;

   // Timer control states shared by all tick consumers
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } tick_timer_state_t;

endpackage : tick_pkg

// File: rtl/tick_edge.sv
// Rising-edge detector turning the level tick_in into a one-cycle tick pulse.
// Latency: combinational pulse in the cycle tick_in first reads high.
// Backpressure: none; a level held high yields exactly one pulse.
module tick_edge (
   input  logic clk,
   input  logic rst,
   input  logic tick_in,
   output logic tick
);

   logic r_tick_q;

   // Track previous tick_in; reset to 1 so a level already high at release is not a tick
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_q <= 1'b1;
      end else begin
         r_tick_q <= tick_in;
      end
   end

   assign tick = tick_in & ~r_tick_q;

endmodule : tick_edge

// File: rtl/tick_timer.sv
// Loadable down-counter timer decremented on tick_in rising edges; sticky irq on expiry.
// Latency: load/start/tick effects are visible one cycle after the strobe (registered).
// Backpressure: none; strobes are single-cycle and always accepted. Optional TICK_TIMER_AUTORELOAD_EN.
module tick_timer
   import tick_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_in,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             stop,
   input  logic             irq_ack,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             irq
);

   tick_timer_state_t r_state;
   logic [WIDTH-1:0]  r_count;
   logic [WIDTH-1:0]  r_reload;
   logic              r_irq;
   logic              w_tick;
   logic              w_start;

   tick_edge u_tick_edge (
      .clk     (clk),
      .rst     (rst),
      .tick_in (tick_in),
      .tick    (w_tick)
   );

   // stop wins over start when both arrive together
   assign w_start = start & ~stop;

   // Timer FSM, counter, reload register and sticky irq (a later set overrides the ack clear)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_irq    <= 1'b0;
      end else begin
         if (irq_ack) begin
            r_irq <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (load_valid) begin
                  r_reload <= load_value;
                  r_count  <= load_value;
               end
               if (w_start && (r_count != '0)) begin
                  r_state <= RUN;
               end
            end
            EXPIRED: begin
               if (load_valid) begin
                  r_reload <= load_value;
                  r_count  <= load_value;
               end
               if (w_start && (r_reload != '0)) begin
                  r_count <= r_reload;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (load_valid) begin
                  r_reload <= load_value;
               end
               if (stop) begin
                  r_state <= IDLE;
               end else if (w_tick) begin
                  if (r_count == WIDTH'(1)) begin
                     r_irq <= 1'b1;
`ifdef TICK_TIMER_AUTORELOAD_EN
                     if (r_reload != '0) begin
                        r_count <= r_reload;
                     end else begin
                        r_count <= '0;
                        r_state <= EXPIRED;
                     end
`else
                     r_count <= '0;
                     r_state <= EXPIRED;
`endif
                  end else begin
                     r_count <= r_count - WIDTH'(1);
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign count = r_count;
   assign irq   = r_irq;
   assign busy  = (r_state == RUN);

endmodule : tick_timer

// File: tb/tb_tick_timer.sv
// Scoreboard bench for tick_timer: stimulus queues expected outputs per clock edge,
// a monitor on the falling edge pops and compares them.
// Build with TICK_TIMER_AUTORELOAD_EN to exercise the auto-reload variant.
module tb_tick_timer;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             tick_in;
   logic             load_valid;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic             stop;
   logic             irq_ack;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             irq;

   typedef struct {
      string            nm;
      int               cyc;
      logic [WIDTH-1:0] c;
      logic             b;
      logic             i;
   } exp_t;

   exp_t sb[$];
   int   edge_cnt = 0;
   int   n_total  = 0;
   int   n_pass   = 0;

   tick_timer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_in    (tick_in),
      .load_valid (load_valid),
      .load_value (load_value),
      .start      (start),
      .stop       (stop),
      .irq_ack    (irq_ack),
      .count      (count),
      .busy       (busy),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Monitor: compare every expectation whose edge has just been sampled
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
         exp_t e;
         e = sb.pop_front();
         n_total++;
         if (e.cyc != edge_cnt) begin
            $display("FAIL %s: expectation for edge %0d not sampled (now edge %0d)", e.nm, e.cyc, edge_cnt);
         end else if (count !== e.c || busy !== e.b || irq !== e.i) begin
            $display("FAIL %s @edge %0d: got count=%0d busy=%b irq=%b, want count=%0d busy=%b irq=%b",
                     e.nm, edge_cnt, count, busy, irq, e.c, e.b, e.i);
         end else begin
            n_pass++;
         end
      end
   end

   // Queue the expected outputs after the next edge, then advance past it
   task automatic step(input string nm, input logic [WIDTH-1:0] c, input logic b, input logic i);
      exp_t e;
      e.nm  = nm;
      e.cyc = edge_cnt + 1;
      e.c   = c;
      e.b   = b;
      e.i   = i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      irq_ack    = 1'b0;
   endtask

   task automatic tick_step(input string nm, input logic [WIDTH-1:0] c, input logic b, input logic i);
      tick_in = 1'b1;
      step(nm, c, b, i);
      tick_in = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [WIDTH-1:0] v);
      load_valid = 1'b1;
      load_value = v;
   endtask

   initial begin
      rst        = 1'b1;
      tick_in    = 1'b0;
      load_valid = 1'b0;
      load_value = '0;
      start      = 1'b0;
      stop       = 1'b0;
      irq_ack    = 1'b0;

      // Reset state
      step("reset0", 0, 0, 0);
      step("reset1", 0, 0, 0);
      rst = 1'b0;

      // start with count == 0 is ignored
      start = 1'b1;
      step("start_zero", 0, 0, 0);

      // Level held high for 20 cycles gives a single decrement
      do_load(7);
      step("load7", 7, 0, 0);
      start = 1'b1;
      step("start7", 7, 1, 0);
      tick_in = 1'b1;
      step("tick_rise", 6, 1, 0);
      for (int k = 0; k < 19; k++) step("held_high", 6, 1, 0);
      tick_in = 1'b0;
      step("held_low", 6, 1, 0);

      // Stop with coinciding tick, then resume
      stop = 1'b1;
      step("stop7", 6, 0, 0);
      do_load(5);
      step("load5", 5, 0, 0);
      start = 1'b1;
      step("start5", 5, 1, 0);
      tick_step("t5_1", 4, 1, 0);
      idle(9);
      tick_step("t5_2", 3, 1, 0);
      idle(9);
      stop = 1'b1;
      tick_step("stop_tick", 3, 0, 0);
      idle(3);
      start = 1'b1;
      step("resume", 3, 1, 0);
      tick_step("resume_tick", 2, 1, 0);
      idle(9);

      // Reset mid-RUN with tick_in high
      tick_in = 1'b1;
      step("pre_rst_tick", 1, 1, 0);
      rst = 1'b1;
      step("rst_mid", 0, 0, 0);
      rst = 1'b0;
      step("rst_release", 0, 0, 0);
      do_load(4);
      step("load4_high", 4, 0, 0);
      start = 1'b1;
      step("start4_high", 4, 1, 0);
      step("no_dec_high", 4, 1, 0);
      stop = 1'b1;
      step("stop4", 4, 0, 0);
      tick_in = 1'b0;
      idle(2);

`ifdef TICK_TIMER_AUTORELOAD_EN
      // Auto-reload: load 2 -> 1,2,1,2 with irq on ticks 2 and 4
      do_load(2);
      step("ar_load2", 2, 0, 0);
      start = 1'b1;
      step("ar_start", 2, 1, 0);
      tick_step("ar_t1", 1, 1, 0);
      idle(9);
      tick_step("ar_t2", 2, 1, 1);
      irq_ack = 1'b1;
      step("ar_ack", 2, 1, 0);
      idle(8);
      tick_step("ar_t3", 1, 1, 0);
      idle(9);
      tick_step("ar_t4", 2, 1, 1);
      // reload 0 falls back to one-shot expiry
      do_load(0);
      step("ar_load0_run", 2, 1, 1);
      tick_step("ar_t5", 1, 1, 1);
      idle(9);
      tick_step("ar_t6_expire", 0, 0, 1);
`else
      // One-shot: load 3, ticks 10 cycles apart -> 2,1,0 with irq and busy low on the 3rd
      do_load(3);
      step("load3", 3, 0, 0);
      start = 1'b1;
      step("start3", 3, 1, 0);
      idle(4);
      tick_step("t3_1", 2, 1, 0);
      idle(9);
      tick_step("t3_2", 1, 1, 0);
      idle(9);
      tick_step("t3_3_expire", 0, 0, 1);
      step("expired_hold", 0, 0, 1);
      irq_ack = 1'b1;
      step("ack", 0, 0, 0);
      // Restart from EXPIRED reloads the counter
      start = 1'b1;
      step("restart_exp", 3, 1, 0);
      stop = 1'b1;
      step("stop3", 3, 0, 0);
      do_load(2);
      step("load2", 2, 0, 0);
      start = 1'b1;
      step("start2", 2, 1, 0);
      // Load in RUN changes reload only
      do_load(9);
      step("load9_run", 2, 1, 0);
      tick_step("t2_1", 1, 1, 0);
      idle(9);
      // Expiry with simultaneous ack: set wins
      irq_ack = 1'b1;
      tick_step("expire_ack", 0, 0, 1);
      irq_ack = 1'b1;
      step("ack_next", 0, 0, 0);
      start = 1'b1;
      step("restart9", 9, 1, 0);
      stop = 1'b1;
      step("stop9", 9, 0, 0);
`endif

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 5 && sb.size() != 0; k++) @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_tick_timer

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the counter/reload width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port tick_in  input  1  level-type periodic enable from the upstream clock-enable generator; only its rising edge is consumed.
REQ-005 SHALL have port load_valid  input  1  one-cycle strobe qualifying load_value.
REQ-006 SHALL have port load_value  input  WIDTH  new reload/count value.
REQ-007 SHALL have port start  input  1  one-cycle strobe requesting RUN.
REQ-008 SHALL have port stop  input  1  one-cycle strobe requesting IDLE.
REQ-009 SHALL have port irq_ack  input  1  one-cycle strobe clearing irq.
REQ-010 SHALL have port count  output  WIDTH  current counter value, registered.
REQ-011 SHALL have port busy  output  1  high exactly while the FSM is in RUN.
REQ-012 SHALL have port irq  output  1  sticky expiry flag, registered.

Function
REQ-013 SHALL detect a tick as tick_in=1 and tick_q=0, where tick_q is tick_in registered every cycle.
REQ-014 SHALL implement the FSM states IDLE, RUN and EXPIRED.
REQ-015 SHALL, on load_valid in IDLE or EXPIRED: reload <= load_value and count <= load_value, visible on the next cycle; state unchanged.
REQ-016 SHALL, on load_valid in RUN: update reload only; count unaffected.
REQ-017 SHALL move IDLE -> RUN on start when count != 0; start with count == 0 is ignored.
REQ-018 SHALL move EXPIRED -> RUN on start when reload != 0 and set count <= reload in that transition; otherwise the start is ignored.
REQ-019 SHALL, in RUN, decrement count by 1 on each detected tick; no change without a tick.
REQ-020 SHALL, in RUN, on a tick with count == 1: count <= 0, irq <= 1, state -> EXPIRED, all on the same clock edge.
REQ-021 SHALL move RUN -> IDLE on stop and hold count; stop outside RUN is ignored.
REQ-022 SHALL give stop priority over start when both are asserted in the same cycle; load_valid in the same cycle is still applied per REQ-015/016.
REQ-023 SHALL ignore a tick coinciding with stop (count is not decremented).
REQ-024 SHALL clear irq on irq_ack; when a set per REQ-020 and irq_ack occur in the same cycle, set wins.
REQ-025 SHALL drive busy combinationally from the state register (busy = state==RUN).

Reset
REQ-026 SHALL on rst: state=IDLE, count=0, reload=0, irq=0, tick_q=1 (no spurious tick if tick_in is high at release); rst overrides all other inputs, including mid-RUN.

Configuration
REQ-027 SHALL, with macro TICK_TIMER_AUTORELOAD_EN defined, replace the REQ-020 transition with the following: on a tick with count == 1, irq <= 1, count <= reload, state remains RUN; if reload == 0, the REQ-020 behaviour applies instead.
REQ-028 SHALL, without TICK_TIMER_AUTORELOAD_EN, behave as one-shot exactly per REQ-020 and contain no auto-reload logic.

Structure
REQ-029 SHALL take the state enum type (tick_timer_state_t: IDLE, RUN, EXPIRED) from the shared package tick_pkg, which is also reused by other tick consumers.
REQ-030 SHALL instantiate one sub-module, tick_edge, containing the tick_q register and the edge detect; everything else stays in tick_timer.

Verification
REQ-031 SHALL cover: load 3, start, 3 ticks spaced 10 cycles apart -> count 3,2,1,0; irq=1 and busy=0 on the clock edge of the 3rd tick.
REQ-032 SHALL cover: tick_in held high for 20 cycles -> exactly one decrement.
REQ-033 SHALL cover: load 5, start, 2 ticks, stop together with a tick -> count=3, state IDLE; start again -> resumes from 3.
REQ-034 SHALL cover: irq_ack in the same cycle as expiry -> irq=1; irq_ack on the next cycle -> irq=0.
REQ-035 SHALL cover: rst asserted mid-RUN with tick_in high -> count=0, irq=0, busy=0; no decrement on the first cycle after release.
REQ-036 SHALL cover, with TICK_TIMER_AUTORELOAD_EN: load 2, start, 4 ticks -> count 1,2,1,2, irq set on ticks 2 and 4, busy stays 1.
